// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg
// Shared types and constants for the two-requester memory access arbiter.
//   state_e    : arbiter FSM states
//   size_e     : access size encoding used on the requester ports
//   REQUESTERS : number of requester ports served by the arbiter
package memory_arbiter_pkg;

    localparam int REQUESTERS = 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESPOND
    } state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD,
        SIZE_ILLEGAL
    } size_e;

endpackage

// File: rtl/subword_lane_unit.sv
// subword_lane_unit
// Combinational byte-lane helper for the memory access arbiter.
// Ports:
//   size, offset  : latched access size and byte address bits [1:0]
//   store_data    : right-aligned store data
//   word_in       : word read from the backend
//   merged        : word_in with the addressed lanes replaced by store_data
//   load_data     : addressed lanes of word_in, right-aligned, zero-extended
//   check_size,
//   check_offset  : size and address bits [1:0] of the request being sampled
//   misaligned    : high when the sampled request is misaligned or illegal
module subword_lane_unit
    import memory_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] word_in,
    output logic [31:0] merged,
    output logic [31:0] load_data,
    input  logic [1:0]  check_size,
    input  logic [1:0]  check_offset,
    output logic        misaligned
);

    logic [4:0]  shift;
    logic [31:0] lane_mask;

    // Little-endian lanes: the byte offset times eight is the bit shift.
    // Aligned halfwords only ever see offset 0 or 2, so the same shift
    // selects the halfword lane.
    always_comb begin
        shift = {offset, 3'b000};
        case (size)
            SIZE_BYTE: lane_mask = 32'h0000_00FF;
            SIZE_HALF: lane_mask = 32'h0000_FFFF;
            default:   lane_mask = 32'hFFFF_FFFF;
        endcase
        merged    = (word_in & ~(lane_mask << shift)) | ((store_data & lane_mask) << shift);
        load_data = (word_in >> shift) & lane_mask;
    end

    // Size 11 is never legal, regardless of address.
    always_comb begin
        case (check_size)
            SIZE_HALF: misaligned = check_offset[0];
            SIZE_WORD: misaligned = |check_offset;
            SIZE_BYTE: misaligned = 1'b0;
            default:   misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/memory_access_arbiter.sv
// memory_access_arbiter
// Arbitrates between the core data port (requester 0) and the debug/loader
// port (requester 1) for a word-addressed backend, one access at a time.
// Byte/halfword stores are done as read-modify-write.
// Ports:
//   clock, reset (async, active-low)
//   r0*/r1*  : Request, Write, Size, Address, WriteData in;
//              Ready, Error, ReadData out (one-cycle completion pulse)
//   backendAddress/backendDataIn/backendWriteEnable out, backendDataOut in
//              (read data valid one cycle after the address)
// Configuration macro MEMORY_ARBITER_FIXED_PRIORITY_EN: when defined,
// requester 0 always wins collisions; otherwise collisions alternate.
module memory_access_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  r0Request,
    input  logic                  r0Write,
    input  logic [1:0]            r0Size,
    input  logic [ADDR_WIDTH-1:0] r0Address,
    input  logic [31:0]           r0WriteData,
    output logic                  r0Ready,
    output logic                  r0Error,
    output logic [31:0]           r0ReadData,
    input  logic                  r1Request,
    input  logic                  r1Write,
    input  logic [1:0]            r1Size,
    input  logic [ADDR_WIDTH-1:0] r1Address,
    input  logic [31:0]           r1WriteData,
    output logic                  r1Ready,
    output logic                  r1Error,
    output logic [31:0]           r1ReadData,
    output logic [ADDR_WIDTH-3:0] backendAddress,
    input  logic [31:0]           backendDataOut,
    output logic [31:0]           backendDataIn,
    output logic                  backendWriteEnable
);

    state_e                  state, next_state;
    logic [REQUESTERS-1:0]   req_vec;
    logic                    grant;
    logic                    sel_write;
    logic [1:0]              sel_size;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [31:0]             sel_data;
    logic                    misaligned;
    logic                    lat_write;
    logic [1:0]              lat_size;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [31:0]             lat_data;
    logic                    lat_grant;
    logic                    lat_error;
    logic [31:0]             merged_word;
    logic [31:0]             load_word;

    assign req_vec = {r1Request, r0Request};

`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
    // Requester 0 always wins; requester 1 only when 0 is idle.
    assign grant = ~req_vec[0];
`else
    logic last_grant;

    // On a collision the requester that did not win the previous collision
    // goes first. Uncontested grants leave the history alone.
    always_comb begin
        if (&req_vec) begin
            grant = ~last_grant;
        end else begin
            grant = ~req_vec[0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && (&req_vec)) begin
            last_grant <= grant;
        end
    end
`endif

    assign sel_write = grant ? r1Write     : r0Write;
    assign sel_size  = grant ? r1Size      : r0Size;
    assign sel_addr  = grant ? r1Address   : r0Address;
    assign sel_data  = grant ? r1WriteData : r0WriteData;

    subword_lane_unit lane_unit (
        .size         (lat_size),
        .offset       (lat_addr[1:0]),
        .store_data   (lat_data),
        .word_in      (backendDataOut),
        .merged       (merged_word),
        .load_data    (load_word),
        .check_size   (sel_size),
        .check_offset (sel_addr[1:0]),
        .misaligned   (misaligned)
    );

    // State register and the request latch captured when leaving IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lat_write <= 1'b0;
            lat_size  <= 2'b00;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_grant <= 1'b0;
            lat_error <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && (|req_vec)) begin
                lat_write <= sel_write;
                lat_size  <= sel_size;
                lat_addr  <= sel_addr;
                lat_data  <= sel_data;
                lat_grant <= grant;
                lat_error <= misaligned;
            end
        end
    end

    // Word stores skip the read; sub-word stores read first so the
    // untouched lanes can be merged back in WRITE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (|req_vec) begin
                    if (misaligned) begin
                        next_state = RESPOND;
                    end else if (sel_write && sel_size == SIZE_WORD) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ:    next_state = lat_write ? WRITE : RESPOND;
            WRITE:   next_state = IDLE;
            RESPOND: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded purely from state so an asynchronous reset
    // silences the backend and both requesters at once.
    always_comb begin
        r0Ready            = 1'b0;
        r0Error            = 1'b0;
        r0ReadData         = '0;
        r1Ready            = 1'b0;
        r1Error            = 1'b0;
        r1ReadData         = '0;
        backendAddress     = '0;
        backendDataIn      = '0;
        backendWriteEnable = 1'b0;
        case (state)
            READ: begin
                backendAddress = lat_addr[ADDR_WIDTH-1:2];
            end
            WRITE: begin
                backendAddress     = lat_addr[ADDR_WIDTH-1:2];
                backendWriteEnable = 1'b1;
                backendDataIn      = merged_word;
                if (lat_grant) begin
                    r1Ready = 1'b1;
                end else begin
                    r0Ready = 1'b1;
                end
            end
            RESPOND: begin
                if (lat_grant) begin
                    r1Ready    = 1'b1;
                    r1Error    = lat_error;
                    r1ReadData = lat_error ? 32'h0 : load_word;
                end else begin
                    r0Ready    = 1'b1;
                    r0Error    = lat_error;
                    r0ReadData = lat_error ? 32'h0 : load_word;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_access_arbiter.sv
// tb_memory_access_arbiter
// Self-checking bench for memory_access_arbiter: a word memory model on the
// backend, a table of single accesses, a collision sequence and a reset
// abort sequence. Completions are checked against an expectation queue.
module tb_memory_access_arbiter;

    logic        clock;
    logic        reset;
    logic        r0Request, r0Write, r1Request, r1Write;
    logic [1:0]  r0Size, r1Size;
    logic [31:0] r0Address, r0WriteData, r1Address, r1WriteData;
    logic        r0Ready, r0Error, r1Ready, r1Error;
    logic [31:0] r0ReadData, r1ReadData;
    logic [29:0] backendAddress;
    logic [31:0] backendDataOut;
    logic [31:0] backendDataIn;
    logic        backendWriteEnable;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
        bit          err;
        bit          check_data;
    } exp_t;

    typedef struct {
        int          id;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_err;
        int          exp_lat;
        int          exp_writes;
        logic [31:0] exp_wdata;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[13];

    logic [31:0] mem [0:63];
    logic        preload_en;
    logic [5:0]  preload_addr;
    logic [31:0] preload_data;
    int          wr_count = 0;
    logic [29:0] last_waddr;
    logic [31:0] last_wdata;

    memory_access_arbiter #(.ADDR_WIDTH(32)) dut (
        .clock              (clock),
        .reset              (reset),
        .r0Request          (r0Request),
        .r0Write            (r0Write),
        .r0Size             (r0Size),
        .r0Address          (r0Address),
        .r0WriteData        (r0WriteData),
        .r0Ready            (r0Ready),
        .r0Error            (r0Error),
        .r0ReadData         (r0ReadData),
        .r1Request          (r1Request),
        .r1Write            (r1Write),
        .r1Size             (r1Size),
        .r1Address          (r1Address),
        .r1WriteData        (r1WriteData),
        .r1Ready            (r1Ready),
        .r1Error            (r1Error),
        .r1ReadData         (r1ReadData),
        .backendAddress     (backendAddress),
        .backendDataOut     (backendDataOut),
        .backendDataIn      (backendDataIn),
        .backendWriteEnable (backendWriteEnable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Backend word memory: registered read, so data follows the address by
    // one cycle; writes land on the clock edge that ends the WRITE cycle.
    always @(posedge clock) begin
        backendDataOut <= mem[backendAddress[5:0]];
        if (preload_en) begin
            mem[preload_addr] <= preload_data;
        end else if (backendWriteEnable) begin
            mem[backendAddress[5:0]] <= backendDataIn;
            wr_count   <= wr_count + 1;
            last_waddr <= backendAddress;
            last_wdata <= backendDataIn;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every ready pulse must match the oldest expectation.
    always @(negedge clock) begin
        if (r0Ready || r1Ready) begin
            if (r0Ready && r1Ready) begin
                checkOutput("dual_ready", 32'd1, 32'd0);
            end else if (sb.size() == 0) begin
                checkOutput("unexpected_ready", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("sb_requester", r1Ready ? 32'd1 : 32'd0, mon_e.id);
                checkOutput("sb_error", {31'd0, r1Ready ? r1Error : r0Error}, {31'd0, mon_e.err});
                if (mon_e.check_data) begin
                    checkOutput("sb_read_data", r1Ready ? r1ReadData : r0ReadData, mon_e.data);
                end
                if (r1Ready) begin
                    checkOutput("r0_quiet", {31'd0, r0Error} | r0ReadData, 32'd0);
                end else begin
                    checkOutput("r1_quiet", {31'd0, r1Error} | r1ReadData, 32'd0);
                end
            end
        end
    end

    task automatic pushExpect(input int id, input logic [31:0] data, input bit err, input bit check_data);
        exp_t e;
        e.id         = id;
        e.data       = data;
        e.err        = err;
        e.check_data = check_data;
        sb.push_back(e);
    endtask

    // Drive one request, hold it until its ready, then drop it.
    // exp_lat < 0 skips the latency check (used for contested requests).
    task automatic applyStimulus(input int id, input bit wr, input logic [1:0] sz,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int exp_lat);
        int k;
        bit got;
        @(negedge clock);
        if (id == 0) begin
            r0Request = 1'b1; r0Write = wr; r0Size = sz; r0Address = addr; r0WriteData = wdata;
        end else begin
            r1Request = 1'b1; r1Write = wr; r1Size = sz; r1Address = addr; r1WriteData = wdata;
        end
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            @(negedge clock);
            k++;
            got = (id == 0) ? r0Ready : r1Ready;
        end
        if (!got) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
        end else if (exp_lat >= 0) begin
            checkOutput("latency", k, exp_lat);
        end
        if (id == 0) r0Request = 1'b0;
        else         r1Request = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0;
        reset       = 1'b0;
        r0Request   = 1'b0; r0Write = 1'b0; r0Size = 2'b00; r0Address = '0; r0WriteData = '0;
        r1Request   = 1'b0; r1Write = 1'b0; r1Size = 2'b00; r1Address = '0; r1WriteData = '0;
        preload_en  = 1'b0;
        preload_addr = '0;
        preload_data = '0;

        // Preload backend memory while the arbiter is held in reset.
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            preload_en   = 1'b1;
            preload_addr = 6'(i);
            case (i)
                2:       preload_data = 32'h5566_7788;
                4:       preload_data = 32'h1122_3344;
                5:       preload_data = 32'hA5B6_C7D8;
                default: preload_data = 32'h0;
            endcase
        end
        @(negedge clock);
        preload_en = 1'b0;

        checkOutput("rst_r0Ready", {31'd0, r0Ready}, 32'd0);
        checkOutput("rst_r1Ready", {31'd0, r1Ready}, 32'd0);
        checkOutput("rst_r0Error", {31'd0, r0Error}, 32'd0);
        checkOutput("rst_r1Error", {31'd0, r1Error}, 32'd0);
        checkOutput("rst_r0ReadData", r0ReadData, 32'd0);
        checkOutput("rst_r1ReadData", r1ReadData, 32'd0);
        checkOutput("rst_backendAddress", {2'b00, backendAddress}, 32'd0);
        checkOutput("rst_backendDataIn", backendDataIn, 32'd0);
        checkOutput("rst_backendWriteEnable", {31'd0, backendWriteEnable}, 32'd0);
        reset = 1'b1;

        //           id wr size   addr    wdata          exp_data       err lat wr exp_wdata
        vecs[0]  = '{0, 0, 2'b10, 32'h10, 32'h0,         32'h1122_3344, 0,  2,  0, 32'h0};
        vecs[1]  = '{0, 1, 2'b00, 32'h12, 32'h0000_00AA, 32'h0,         0,  2,  1, 32'h11AA_3344};
        vecs[2]  = '{0, 0, 2'b01, 32'h12, 32'h0,         32'h0000_11AA, 0,  2,  0, 32'h0};
        vecs[3]  = '{1, 0, 2'b10, 32'h13, 32'h0,         32'h0,         1,  1,  0, 32'h0};
        vecs[4]  = '{1, 0, 2'b01, 32'h11, 32'h0,         32'h0,         1,  1,  0, 32'h0};
        vecs[5]  = '{0, 1, 2'b10, 32'h20, 32'hDEAD_BEEF, 32'h0,         0,  1,  1, 32'hDEAD_BEEF};
        vecs[6]  = '{1, 0, 2'b10, 32'h20, 32'h0,         32'hDEAD_BEEF, 0,  2,  0, 32'h0};
        vecs[7]  = '{1, 0, 2'b00, 32'h17, 32'h0,         32'h0000_00A5, 0,  2,  0, 32'h0};
        vecs[8]  = '{0, 1, 2'b01, 32'h16, 32'h0000_1234, 32'h0,         0,  2,  1, 32'h1234_C7D8};
        vecs[9]  = '{1, 0, 2'b10, 32'h14, 32'h0,         32'h1234_C7D8, 0,  2,  0, 32'h0};
        vecs[10] = '{0, 0, 2'b11, 32'h00, 32'h0,         32'h0,         1,  1,  0, 32'h0};
        vecs[11] = '{0, 1, 2'b11, 32'h04, 32'hFFFF_FFFF, 32'h0,         1,  1,  0, 32'h0};
        vecs[12] = '{1, 0, 2'b00, 32'h15, 32'h0,         32'h0000_00C7, 0,  2,  0, 32'h0};

        for (int v = 0; v < 13; v++) begin
            w0 = wr_count;
            pushExpect(vecs[v].id, vecs[v].exp_data, vecs[v].exp_err, !vecs[v].wr || vecs[v].exp_err);
            applyStimulus(vecs[v].id, vecs[v].wr, vecs[v].size, vecs[v].addr, vecs[v].wdata, vecs[v].exp_lat);
            @(posedge clock);
            #1;
            checkOutput("write_count", wr_count - w0, vecs[v].exp_writes);
            if (vecs[v].exp_writes != 0) begin
                checkOutput("write_address", {2'b00, last_waddr}, {2'b00, vecs[v].addr[31:2]});
                checkOutput("write_data", last_wdata, vecs[v].exp_wdata);
            end
        end

        // Two collisions: the first goes to r0; the second alternates
        // unless fixed priority is configured.
        $display("[TB] collision sequence");
        pushExpect(0, 32'h11AA_3344, 1'b0, 1'b1);
        pushExpect(1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        fork
            applyStimulus(0, 1'b0, 2'b10, 32'h10, 32'h0, 2);
            applyStimulus(1, 1'b0, 2'b10, 32'h20, 32'h0, -1);
        join
`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
        pushExpect(0, 32'h11AA_3344, 1'b0, 1'b1);
        pushExpect(1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        fork
            applyStimulus(0, 1'b0, 2'b10, 32'h10, 32'h0, 2);
            applyStimulus(1, 1'b0, 2'b10, 32'h20, 32'h0, -1);
        join
`else
        pushExpect(1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        pushExpect(0, 32'h11AA_3344, 1'b0, 1'b1);
        fork
            applyStimulus(0, 1'b0, 2'b10, 32'h10, 32'h0, -1);
            applyStimulus(1, 1'b0, 2'b10, 32'h20, 32'h0, 2);
        join
`endif

        // Reset during the read phase of a byte store must abort it.
        $display("[TB] reset abort sequence");
        @(negedge clock);
        r0Request = 1'b1; r0Write = 1'b1; r0Size = 2'b00; r0Address = 32'h08; r0WriteData = 32'h11;
        @(posedge clock);
        #1;
        checkOutput("abort_read_address", {2'b00, backendAddress}, 32'h2);
        w0 = wr_count;
        reset = 1'b0;
        #1;
        checkOutput("abort_backendAddress", {2'b00, backendAddress}, 32'd0);
        checkOutput("abort_writeEnable", {31'd0, backendWriteEnable}, 32'd0);
        checkOutput("abort_r0Ready", {31'd0, r0Ready}, 32'd0);
        r0Request = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("abort_no_write", wr_count - w0, 32'd0);
        pushExpect(0, 32'h5566_7788, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 2'b10, 32'h08, 32'h0, 2);

        repeat (3) @(negedge clock);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access_arbiter.md
Name: memory_access_arbiter

Overview:
- Sits between two requesters (core data port = requester 0, debug/loader port = requester 1) and the word-addressed memory backend read/write port.
- Arbitrates one access at a time and converts byte-addressed byte/halfword/word requests into backend word accesses.
- Sub-word stores are done as read-modify-write.
- Instruction fetch port is not touched.

Parameters:
- ADDR_WIDTH, 32, byte-address width of requester ports; backend address is ADDR_WIDTH-2 bits.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- r0Request / r1Request  input  1  access request; held with fields stable until matching ready
- r0Write / r1Write  input  1  1 = store, 0 = load
- r0Size / r1Size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- r0Address / r1Address  input  ADDR_WIDTH  byte address
- r0WriteData / r1WriteData  input  32  store data, right-aligned
- r0Ready / r1Ready  output  1  one-cycle completion pulse
- r0Error / r1Error  output  1  pulses with ready on misaligned/illegal request
- r0ReadData / r1ReadData  output  32  load data, right-aligned, zero-extended; valid only while ready is high
- backendAddress  output  ADDR_WIDTH-2  word address
- backendDataOut  input  32  backend read data; valid one cycle after address is presented
- backendDataIn  output  32  backend write data
- backendWriteEnable  output  1  word write strobe

Behaviour:
- Reset (async, active-low): FSM to IDLE; all outputs 0; lastGrant = 1, so r0 wins the first collision; latched request cleared.
- FSM states: IDLE, READ, WRITE, RESPOND.
- IDLE:
  - Samples requests and picks a winner, round-robin: when both request, grant the one not in lastGrant; update lastGrant.
  - Latches write, size, address and data.
  - Alignment check: halfword needs addr[0]=0; word needs addr[1:0]=00; size 11 is always illegal.
  - Illegal request → RESPOND with error = 1; no backend access.
  - Word store → WRITE.
  - Everything else → READ.
- READ: drive backendAddress = addr[ADDR_WIDTH-1:2], writeEnable 0. Next state: WRITE for sub-word store, RESPOND for load.
- WRITE:
  - Drive backendAddress and backendWriteEnable = 1.
  - backendDataIn = store data (word store) or backendDataOut with the selected lanes replaced (little-endian; byte lane = addr[1:0], halfword lane = addr[1]).
  - Pulse ready in this same cycle, then → IDLE.
- RESPOND:
  - Pulse ready (and error if flagged) to the granted requester.
  - ReadData = backendDataOut shifted right by 8*addr[1:0] and masked to size (0 on error).
  - → IDLE.
- Latency from the request-sampled cycle N:
  - load: ready at N+2
  - word store: ready at N+1
  - sub-word store: ready at N+2
  - error: ready at N+1
- A new request can be sampled the cycle after ready (IDLE); no back-to-back in the ready cycle.
- The non-granted requester's ready, error and readData stay 0.
- backendWriteEnable is high only in WRITE and never for an erroring request.
- Reset mid-operation aborts immediately: no partial write and no ready pulse.

Optional Feature:
- Macro MEMORY_ARBITER_FIXED_PRIORITY_EN.
- Defined: r0 always wins collisions; lastGrant is not implemented.
- Undefined: round-robin as above.

Decomposition:
- Package memory_arbiter_pkg:
  - state enum {IDLE, READ, WRITE, RESPOND}
  - size enum {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_ILLEGAL}
  - constant REQUESTERS = 2
- Sub-module subword_lane_unit (combinational): lane merge for stores, shift/mask extraction for loads, alignment check.

Test Plan:
- Word load: backend word 4 = 0x11223344; r0 reads 0x10 size 10 → r0Ready at N+2, r0ReadData 0x11223344, backendWriteEnable never high.
- Byte store: r0 writes 0x000000AA to 0x12 size 00 → backendAddress 0x4 read at N+1; write at N+2 with backendDataIn 0x11AA3344 and r0Ready. A following halfword load of 0x12 → 0x000011AA.
- Collision: r0 and r1 request loads together twice → first r0 then r1; on the second simultaneous pair r1 goes first (round-robin). With macro defined, r0 wins both.
- Misaligned: r1 word load at 0x13 → r1Ready and r1Error at N+1, r1ReadData 0, no backend write; halfword at 0x11 gives the same result.
- Word store: r0 writes 0xDEADBEEF to 0x20 → backendWriteEnable, address 0x8, data 0xDEADBEEF, r0Ready at N+1.
- Reset: assert reset in READ of a sub-word store → outputs 0 immediately, no writeEnable pulse, IDLE after release, word unchanged on readback.
